multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: fetch/decode/execute FSM that drives datapath muxes,
// memory strobes and PC enables, and counts retired instructions.
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op_code,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond_eq,
  output logic        pc_write_cond_ne,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond_eq;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] instr_count_q, instr_count_d;
  ctl_t        ctl;
  ctl_t        ctl_o;

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ctl.alu_src_b = 2'b11;
        // The opcode is only being captured on this edge, so dispatch uses the live input.
        case (op_code)
          OP_R:             state_d = EXEC;
          OP_LW, OP_SW:     state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_ADDI, OP_ANDI: state_d = I_EXEC;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_d = TRAP;
            end else begin
              state_d        = FETCH;
              ctl.instr_done = 1'b1;
            end
          end
        endcase
      end
      MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (mem_ready) begin
          ctl.instr_done = 1'b1;
          state_d        = FETCH;
        end
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = R_WB;
      end
      R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a        = 1'b1;
        ctl.alu_op           = 2'b01;
        ctl.pc_source        = 2'b01;
        ctl.pc_write_cond_eq = (op_q == OP_BEQ);
        ctl.pc_write_cond_ne = (op_q == OP_BNE);
        ctl.instr_done       = 1'b1;
        state_d              = FETCH;
      end
      JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
        state_d       = I_WB;
      end
      I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      TRAP: begin
        ctl.illegal_op = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    op_d          = (state_q == DECODE) ? op_code : op_q;
    instr_count_d = ctl.instr_done ? instr_count_q + 32'd1 : instr_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      op_q          <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Controls are silenced while reset is held; FETCH would otherwise assert mem_read.
  assign ctl_o = rst_n ? ctl : '0;

  assign pc_write         = ctl_o.pc_write;
  assign pc_write_cond_eq = ctl_o.pc_write_cond_eq;
  assign pc_write_cond_ne = ctl_o.pc_write_cond_ne;
  assign i_or_d           = ctl_o.i_or_d;
  assign mem_read         = ctl_o.mem_read;
  assign mem_write        = ctl_o.mem_write;
  assign ir_write         = ctl_o.ir_write;
  assign reg_dst          = ctl_o.reg_dst;
  assign reg_write        = ctl_o.reg_write;
  assign mem_to_reg       = ctl_o.mem_to_reg;
  assign alu_src_a        = ctl_o.alu_src_a;
  assign alu_src_b        = ctl_o.alu_src_b;
  assign alu_op           = ctl_o.alu_op;
  assign pc_source        = ctl_o.pc_source;
  assign instr_done       = ctl_o.instr_done;
  assign illegal_op       = ctl_o.illegal_op;
  assign state            = state_q;
  assign instr_count      = rst_n ? instr_count_q : 32'd0;

endmodule
